flip_sequencer: RTL and testbench

Queues rectangle-flip commands and issues them one at a time to a single `flip_controller` instance, so each flip no longer needs its own hand-driven `start`. It sits between the command source (host or test harness) and the controller. It buffers up to `DEPTH` commands, drives `start`, `base_addr` and the corner indices, and waits for `done`. It also keeps a completed-flip count and raises an optional watchdog error.

---
 rtl/flip_sequencer.sv | 154 +++++++++++++++
 tb/tb_flip_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flip_sequencer.sv
// flip_sequencer: buffers rectangle-flip commands and issues them one at a time to a flip_controller.
// Define FLIP_SEQ_TIMEOUT_EN to build the WAIT-state watchdog and the sticky err flag.
module flip_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [IDX_W-1:0]  cmd_r1,
  input  logic [IDX_W-1:0]  cmd_r2,
  input  logic [IDX_W-1:0]  cmd_c1,
  input  logic [IDX_W-1:0]  cmd_c2,
  output logic              fc_start,
  output logic [ADDR_W-1:0] fc_base_addr,
  output logic [IDX_W-1:0]  fc_r1,
  output logic [IDX_W-1:0]  fc_r2,
  output logic [IDX_W-1:0]  fc_c1,
  output logic [IDX_W-1:0]  fc_c2,
  input  logic              fc_done,
  output logic              busy,
  output logic [7:0]        flip_count,
  output logic              all_done,
  output logic              err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CmdW = ADDR_W + 4 * IDX_W;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state_q, state_d;
  logic [CmdW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic [CmdW-1:0] fc_cmd_q, fc_cmd_d;
  logic            fc_start_q, fc_start_d;
  logic [7:0]      flip_count_q, flip_count_d;
  logic            all_done_q, all_done_d;
  logic            full, empty, push, pop, expire;

  // Readiness depends on the registered count only; a same-cycle pop never frees a full slot.
  assign full      = (count_q == (PtrW + 1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state_q == StIdle) && !empty;
  assign busy      = (state_q != StIdle) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_addr, cmd_r1, cmd_r2, cmd_c1, cmd_c2};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FLIP_SEQ_TIMEOUT_EN
  logic [7:0] wdog_q;
  logic       err_q;

  assign expire = (wdog_q + 8'd1 == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        wdog_q <= '0;
      end else if (state_q == StWait) begin
        wdog_q <= wdog_q + 8'd1;
      end
      // A completion on the expiry cycle takes priority over the error.
      if (state_q == StWait && expire && !fc_done) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire         = 1'b0;
  assign err            = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    fc_cmd_d     = fc_cmd_q;
    fc_start_d   = 1'b0;
    flip_count_d = flip_count_q;
    all_done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          fc_cmd_d   = mem_q[rd_ptr_q];
          fc_start_d = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (fc_done) begin
          flip_count_d = flip_count_q + 8'd1;
          all_done_d   = empty && !push;
          state_d      = StIdle;
        end else if (expire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      fc_cmd_q     <= '0;
      fc_start_q   <= 1'b0;
      flip_count_q <= '0;
      all_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fc_cmd_q     <= fc_cmd_d;
      fc_start_q   <= fc_start_d;
      flip_count_q <= flip_count_d;
      all_done_q   <= all_done_d;
    end
  end

  assign {fc_base_addr, fc_r1, fc_r2, fc_c1, fc_c2} = fc_cmd_q;
  assign fc_start   = fc_start_q;
  assign flip_count = flip_count_q;
  assign all_done   = all_done_q;

endmodule

// File: tb/tb_flip_sequencer.sv
// Scoreboard bench for flip_sequencer: issued commands are queued and matched against each fc_start.
// The watchdog scenario runs only when FLIP_SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_flip_sequencer;

  typedef struct packed {
    logic [7:0] addr;
    logic [1:0] r1;
    logic [1:0] r2;
    logic [1:0] c1;
    logic [1:0] c2;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [1:0] cmd_r1 = '0, cmd_r2 = '0, cmd_c1 = '0, cmd_c2 = '0;
  logic       cmd_ready, fc_start, fc_done, busy, all_done, err;
  logic [7:0] fc_base_addr, flip_count;
  logic [1:0] fc_r1, fc_r2, fc_c1, fc_c2;
  logic       done_auto = 1'b0, done_force = 1'b0;

  assign fc_done = done_auto | done_force;

  int   checks = 0, failures = 0;
  int   n_starts = 0, n_all_done = 0, cyc = 0, done_cyc = 0;
  int   done_delay = 5, exp_count = 0;
  bit   done_seen = 0, gap_en = 0, auto_en = 0;
  cmd_t exp_q[$];
  cmd_t mon_exp;

  flip_sequencer #(
    .DEPTH  (4),
    .ADDR_W (8),
    .IDX_W  (2),
    .TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_r1      (cmd_r1),
    .cmd_r2      (cmd_r2),
    .cmd_c1      (cmd_c1),
    .cmd_c2      (cmd_c2),
    .fc_start    (fc_start),
    .fc_base_addr(fc_base_addr),
    .fc_r1       (fc_r1),
    .fc_r2       (fc_r2),
    .fc_c1       (fc_c1),
    .fc_c2       (fc_c2),
    .fc_done     (fc_done),
    .busy        (busy),
    .flip_count  (flip_count),
    .all_done    (all_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every fc_start and checks the one-idle-cycle issue gap.
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (rst_n) begin
      if (all_done) n_all_done++;
      if (fc_start) begin
        n_starts++;
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 32'd1, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("start_cmd", {16'd0, fc_base_addr, fc_r1, fc_r2, fc_c1, fc_c2}, {16'd0, mon_exp});
        end
        if (gap_en && done_seen) chk("issue_gap", cyc - done_cyc, 32'd2);
        done_seen = 0;
      end
      if (fc_done && gap_en) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
    end else begin
      done_seen = 0;
    end
  end

  // Controller model: answers each fc_start with a one-cycle fc_done after done_delay cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_en && rst_n && fc_start) begin
        repeat (done_delay) @(negedge clk);
        done_auto = 1'b1;
        @(negedge clk);
        done_auto = 1'b0;
      end
    end
  end

  task automatic push_cmd(input cmd_t c, output bit acc);
    cmd_valid = 1'b1;
    cmd_addr  = c.addr;
    cmd_r1    = c.r1;
    cmd_r2    = c.r2;
    cmd_c1    = c.c1;
    cmd_c2    = c.c2;
    acc       = cmd_ready;
    if (acc) exp_q.push_back(c);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_fc_start", {31'd0, fc_start}, 32'd0);
    chk("rst_fc_coords", {16'd0, fc_base_addr, fc_r1, fc_r2, fc_c1, fc_c2}, 32'd0);
    chk("rst_flip_count", {24'd0, flip_count}, 32'd0);
    chk("rst_all_done", {31'd0, all_done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit   acc;
    int   n;
    cmd_t c;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();

    // Single command; controller answers 5 cycles after fc_start.
    auto_en    = 1;
    done_delay = 5;
    c = {8'h10, 2'd0, 2'd2, 2'd1, 2'd3};
    push_cmd(c, acc);
    chk("t1_accept", {31'd0, acc}, 32'd1);
    chk("t1_start_not_yet", {31'd0, fc_start}, 32'd0);
    @(negedge clk);
    chk("t1_start_latency", {31'd0, fc_start}, 32'd1);
    @(negedge clk);
    chk("t1_start_one_cycle", {31'd0, fc_start}, 32'd0);
    wait_idle(50);
    chk("t1_flip_count", {24'd0, flip_count}, 32'd1);
    chk("t1_all_done", n_all_done, 32'd1);
    chk("t1_starts", n_starts, 32'd1);

    // One flip stalled in WAIT, then fill the FIFO and try one more.
    auto_en = 0;
    c = {8'h20, 2'd1, 2'd0, 2'd3, 2'd2};
    push_cmd(c, acc);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      c = {8'h30 + 8'(i), 2'(i), 2'(3 - i), 2'(i + 1), 2'(i + 2)};
      push_cmd(c, acc);
      chk("t2_accept", {31'd0, acc}, 32'd1);
    end
    chk("t2_full_ready", {31'd0, cmd_ready}, 32'd0);
    c = {8'h3f, 2'd3, 2'd3, 2'd3, 2'd3};
    push_cmd(c, acc);
    chk("t2_fifth_refused", {31'd0, acc}, 32'd0);
    chk("t2_still_full", {31'd0, cmd_ready}, 32'd0);
    gap_en     = 1;
    auto_en    = 1;
    done_delay = 2;
    done_force = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    wait_idle(200);
    gap_en = 0;
    chk("t2_flip_count", {24'd0, flip_count}, 32'd6);
    chk("t2_all_done", n_all_done, 32'd2);
    chk("t2_starts", n_starts, 32'd6);

    // fc_done held high through IDLE and ISSUE must only count once in WAIT.
    auto_en    = 0;
    done_force = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_idle_ignored", {24'd0, flip_count}, 32'd6);
    c = {8'h55, 2'd2, 2'd1, 2'd0, 2'd3};
    push_cmd(c, acc);
    chk("t3_before_issue", {24'd0, flip_count}, 32'd6);
    @(negedge clk);
    chk("t3_issue_start", {31'd0, fc_start}, 32'd1);
    chk("t3_issue_count", {24'd0, flip_count}, 32'd6);
    @(negedge clk);
    chk("t3_wait_count", {24'd0, flip_count}, 32'd6);
    @(negedge clk);
    chk("t3_done_in_wait", {24'd0, flip_count}, 32'd7);
    done_force = 1'b0;
    wait_idle(20);
    chk("t3_all_done", n_all_done, 32'd3);
    exp_count = 7;

`ifdef FLIP_SEQ_TIMEOUT_EN
    // Watchdog: first flip never completes, second proceeds.
    c = {8'h60, 2'd0, 2'd1, 2'd2, 2'd3};
    push_cmd(c, acc);
    c = {8'h61, 2'd3, 2'd2, 2'd1, 2'd0};
    push_cmd(c, acc);
    n = 0;
    while (!fc_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t4_start", {31'd0, fc_start}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t4_err_early", {31'd0, err}, 32'd0);
    end
    @(negedge clk);
    chk("t4_err_set", {31'd0, err}, 32'd1);
    chk("t4_count_held", {24'd0, flip_count}, 32'd7);
    auto_en    = 1;
    done_delay = 1;
    wait_idle(50);
    chk("t4_next_done", {24'd0, flip_count}, 32'd8);
    chk("t4_err_sticky", {31'd0, err}, 32'd1);
    exp_count = 8;
`endif

    // Enough completions to wrap flip_count to zero.
    auto_en    = 1;
    done_delay = 1;
    gap_en     = 1;
    for (int i = 0; i < 256 - exp_count; i++) begin
      c   = {8'(i), 2'(i), 2'(i >> 2), 2'(i >> 4), 2'(i >> 6)};
      n   = 0;
      acc = 0;
      while (!acc && n < 20) begin
        push_cmd(c, acc);
        n++;
      end
      if (!acc) chk("t5_push_stuck", 32'd0, 32'd1);
    end
    wait_idle(100);
    gap_en = 0;
    chk("t5_wrap", {24'd0, flip_count}, 32'd0);

    // Reset in WAIT with two commands still queued.
    auto_en = 0;
    for (int i = 0; i < 3; i++) begin
      c = {8'h70 + 8'(i), 2'(i), 2'(i), 2'(i), 2'(i)};
      push_cmd(c, acc);
    end
    repeat (2) @(negedge clk);
    chk("t6_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    n = n_starts;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_no_start", n_starts, n);
    chk("t6_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
